maxnet_weight_store: RTL and testbench

//  Parametrised, writable weight/input store for the N-neuron MaxNet datapath; replaces the fixed 4x4 file-loaded store.

---
 rtl/maxnet_pkg.sv | 21 ++
 rtl/maxnet_reg_array.sv | 53 +++++
 rtl/maxnet_weight_store.sv | 156 +++++++++++++++
 tb/tb_maxnet_weight_store.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maxnet_pkg.sv
// Shared types and defaults for the MaxNet weight/input store.
package maxnet_pkg;

  localparam int unsigned N_DEF     = 4;
  localparam int unsigned WIDTH_DEF = 5;

  localparam logic [WIDTH_DEF-1:0] DIAG_DEF    = 5'b01000;
  localparam logic [WIDTH_DEF-1:0] OFFDIAG_DEF = 5'b11110;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // True when an index addresses an existing entry of an n-entry dimension.
  function automatic logic in_range(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/maxnet_reg_array.sv
// Generic 2-D register file: async reset to a diagonal init pattern,
// one word write port, one combinational full-row read port.
module maxnet_reg_array
  import maxnet_pkg::*;
#(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4,
  parameter int unsigned WIDTH = 5,
  parameter logic [WIDTH-1:0] INIT_DIAG = '0,
  parameter logic [WIDTH-1:0] INIT_OFF  = '0,
  localparam int unsigned RAW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int unsigned CAW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [RAW-1:0]          wr_row,
  input  logic [CAW-1:0]          wr_col,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic [RAW-1:0]          rd_row,
  output logic [COLS*WIDTH-1:0]   rd_data_c
);

  logic [WIDTH-1:0] mem [ROWS][COLS];

  function automatic logic [WIDTH-1:0] init_word(input int unsigned r, input int unsigned c);
    return (r == c) ? INIT_DIAG : INIT_OFF;
  endfunction

  // Storage: reset restores the init pattern, in-range writes land one word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < ROWS; r++) begin
        for (int unsigned c = 0; c < COLS; c++) begin
          mem[r][c] <= init_word(r, c);
        end
      end
    end else if (wr_en && in_range(32'(wr_row), ROWS) && in_range(32'(wr_col), COLS)) begin
      mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Row read: column c packed at [c*WIDTH +: WIDTH]; out-of-range rows read as zero.
  always_comb begin
    rd_data_c = '0;
    if (in_range(32'(rd_row), ROWS)) begin
      for (int unsigned c = 0; c < COLS; c++) begin
        rd_data_c[c*WIDTH +: WIDTH] = mem[rd_row][c];
      end
    end
  end

endmodule

// File: rtl/maxnet_weight_store.sv
// Writable X vector / W matrix store that streams W one row per beat
// alongside a snapshot of X taken when the pass starts.
module maxnet_weight_store
  import maxnet_pkg::*;
#(
  parameter int unsigned N     = N_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter logic [WIDTH-1:0] DIAG    = WIDTH'(DIAG_DEF),
  parameter logic [WIDTH-1:0] OFFDIAG = WIDTH'(OFFDIAG_DEF),
  localparam int unsigned AW = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  x_wr_en,
  input  logic [AW-1:0]         x_wr_addr,
  input  logic [WIDTH-1:0]      x_wr_data,
  input  logic                  w_wr_en,
  input  logic [AW-1:0]         w_wr_row,
  input  logic [AW-1:0]         w_wr_col,
  input  logic [WIDTH-1:0]      w_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  row_valid,
  input  logic                  row_ready,
  output logic [AW-1:0]         row_idx,
  output logic [N*WIDTH-1:0]    row_w,
  output logic [N*WIDTH-1:0]    x_vec,
  output logic                  done,
  output logic                  wr_err
);

  state_t               state;
  logic [WIDTH-1:0]     x_mem [N];
  logic [N*WIDTH-1:0]   x_pack_c;
  logic [N*WIDTH-1:0]   rd_data_c;
  logic [AW-1:0]        rd_row_c;
  logic                 in_stream_c;
  logic                 x_ok_c;
  logic                 x_bad_c;
  logic                 w_ok_c;
  logic                 w_bad_c;
  logic                 beat_c;
  logic                 last_c;

  // Write qualification: nothing lands while streaming, and only in-range indices.
  always_comb begin
    in_stream_c = (state == ST_STREAM);
    x_ok_c  = x_wr_en && !in_stream_c && in_range(32'(x_wr_addr), N);
    x_bad_c = x_wr_en && !x_ok_c;
    w_ok_c  = w_wr_en && !in_stream_c &&
              in_range(32'(w_wr_row), N) && in_range(32'(w_wr_col), N);
    w_bad_c = w_wr_en && !w_ok_c;
    beat_c  = row_valid && row_ready;
    last_c  = (row_idx == AW'(N - 1));
  end

  // Row fetched one cycle ahead: row 0 when launching, the next row while streaming.
  always_comb begin
    rd_row_c = '0;
    if (state == ST_STREAM) begin
      rd_row_c = row_idx + AW'(1);
    end
  end

  // Flatten X into the snapshot packing.
  always_comb begin
    x_pack_c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      x_pack_c[i*WIDTH +: WIDTH] = x_mem[i];
    end
  end

  maxnet_reg_array #(
    .ROWS      (N),
    .COLS      (N),
    .WIDTH     (WIDTH),
    .INIT_DIAG (DIAG),
    .INIT_OFF  (OFFDIAG)
  ) u_w_array (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (w_ok_c),
    .wr_row    (w_wr_row),
    .wr_col    (w_wr_col),
    .wr_data   (w_wr_data),
    .rd_row    (rd_row_c),
    .rd_data_c (rd_data_c)
  );

  // X vector storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        x_mem[i] <= '0;
      end
    end else if (x_ok_c) begin
      x_mem[x_wr_addr] <= x_wr_data;
    end
  end

  // One-cycle error pulse for any rejected write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err <= 1'b0;
    end else begin
      wr_err <= x_bad_c || w_bad_c;
    end
  end

  // Streaming FSM with registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      row_valid <= 1'b0;
      done      <= 1'b0;
      row_idx   <= '0;
      row_w     <= '0;
      x_vec     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_STREAM;
            busy      <= 1'b1;
            row_valid <= 1'b1;
            row_idx   <= '0;
            row_w     <= rd_data_c;
            x_vec     <= x_pack_c;
          end
        end
        ST_STREAM: begin
          if (beat_c) begin
            if (last_c) begin
              state     <= ST_DONE;
              busy      <= 1'b0;
              row_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              row_idx <= row_idx + AW'(1);
              row_w   <= rd_data_c;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_maxnet_weight_store.sv
// Self-checking bench for maxnet_weight_store against an array-level model.
module tb_maxnet_weight_store;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 5;
  localparam int unsigned AW = 2;
  localparam logic [W-1:0] DG = 5'b01000;
  localparam logic [W-1:0] OD = 5'b11110;

  logic clk = 1'b0;
  logic rst;
  logic x_wr_en, w_wr_en, start, row_ready;
  logic [AW-1:0] x_wr_addr, w_wr_row, w_wr_col;
  logic [W-1:0] x_wr_data, w_wr_data;
  logic busy, row_valid, done, wr_err;
  logic [AW-1:0] row_idx;
  logic [N*W-1:0] row_w, x_vec;

  // Second build with N=3 so out-of-range indices are reachable.
  logic x3_en, w3_en, start3, rdy3;
  logic [1:0] x3_addr, w3_row, w3_col;
  logic [W-1:0] x3_data, w3_data;
  logic busy3, valid3, done3, err3;
  logic [1:0] idx3;
  logic [3*W-1:0] row_w3, x_vec3;

  int checks = 0;
  int errors = 0;
  int beats;

  logic [W-1:0] mx [N];
  logic [W-1:0] mw [N][N];

  always #5 clk = ~clk;

  always @(posedge clk) if (row_valid && row_ready) beats++;

  maxnet_weight_store #(.N(N), .WIDTH(W)) u_dut (
    .clk(clk), .rst(rst),
    .x_wr_en(x_wr_en), .x_wr_addr(x_wr_addr), .x_wr_data(x_wr_data),
    .w_wr_en(w_wr_en), .w_wr_row(w_wr_row), .w_wr_col(w_wr_col), .w_wr_data(w_wr_data),
    .start(start), .busy(busy), .row_valid(row_valid), .row_ready(row_ready),
    .row_idx(row_idx), .row_w(row_w), .x_vec(x_vec), .done(done), .wr_err(wr_err)
  );

  maxnet_weight_store #(.N(3), .WIDTH(W)) u_dut3 (
    .clk(clk), .rst(rst),
    .x_wr_en(x3_en), .x_wr_addr(x3_addr), .x_wr_data(x3_data),
    .w_wr_en(w3_en), .w_wr_row(w3_row), .w_wr_col(w3_col), .w_wr_data(w3_data),
    .start(start3), .busy(busy3), .row_valid(valid3), .row_ready(rdy3),
    .row_idx(idx3), .row_w(row_w3), .x_vec(x_vec3), .done(done3), .wr_err(err3)
  );

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mx[i] = '0;
      for (int j = 0; j < N; j++) mw[i][j] = (i == j) ? DG : OD;
    end
  endtask

  function automatic logic [N*W-1:0] row_of(input int r);
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = mw[r][c];
    return v;
  endfunction

  function automatic logic [N*W-1:0] x_of();
    logic [N*W-1:0] v;
    for (int c = 0; c < N; c++) v[c*W +: W] = mx[c];
    return v;
  endfunction

  task automatic write_x(input int a, input logic [W-1:0] d);
    x_wr_en = 1'b1; x_wr_addr = AW'(a); x_wr_data = d;
    @(posedge clk); #1;
    x_wr_en = 1'b0;
    mx[a] = d;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL write_x_err addr=%0d got %b exp 0", a, wr_err);
    end
  endtask

  task automatic write_w(input int r, input int c, input logic [W-1:0] d);
    w_wr_en = 1'b1; w_wr_row = AW'(r); w_wr_col = AW'(c); w_wr_data = d;
    @(posedge clk); #1;
    w_wr_en = 1'b0;
    mw[r][c] = d;
    checks++;
    if (wr_err !== 1'b0) begin
      errors++; $display("FAIL write_w_err r=%0d c=%0d got %b exp 0", r, c, wr_err);
    end
  endtask

  // One full pass from IDLE; ends back in IDLE one cycle after the done pulse.
  task automatic do_pass(input int stall_row, input int stall_n, input bit mid_write,
                         input bit start_write, input bit done_write);
    logic [N*W-1:0] snap;
    logic [N*W-1:0] rows [N];
    logic err_exp;
    int cyc;
    int ns;
    int total_stall;
    snap = x_of();
    for (int r = 0; r < N; r++) rows[r] = row_of(r);
    start = 1'b1; row_ready = 1'b0;
    if (start_write) begin
      x_wr_en = 1'b1; x_wr_addr = '0; x_wr_data = W'($urandom);
      w_wr_en = 1'b1; w_wr_row = '0; w_wr_col = '0; w_wr_data = W'($urandom);
    end
    beats = 0;
    @(posedge clk); #1;
    if (start_write) begin
      mx[0] = x_wr_data; mw[0][0] = w_wr_data;
    end
    start = 1'b0; x_wr_en = 1'b0; w_wr_en = 1'b0;
    err_exp = 1'b0; cyc = 1; total_stall = 0;
    for (int k = 0; k < N; k++) begin
      ns = (k == stall_row) ? stall_n : 0;
      total_stall += ns;
      for (int s = 0; s <= ns; s++) begin
        checks++;
        if ({busy, row_valid, done, wr_err} !== {1'b1, 1'b1, 1'b0, err_exp}) begin
          errors++; $display("FAIL stream_status k=%0d s=%0d got %b exp %b", k, s,
                             {busy, row_valid, done, wr_err}, {1'b1, 1'b1, 1'b0, err_exp});
        end
        checks++;
        if (row_idx !== AW'(k)) begin
          errors++; $display("FAIL row_idx k=%0d got %0d exp %0d", k, row_idx, k);
        end
        checks++;
        if (row_w !== rows[k]) begin
          errors++; $display("FAIL row_w k=%0d got %h exp %h", k, row_w, rows[k]);
        end
        checks++;
        if (x_vec !== snap) begin
          errors++; $display("FAIL x_vec k=%0d got %h exp %h", k, x_vec, snap);
        end
        row_ready = (s == ns);
        start = 1'($urandom_range(0, 1));
        err_exp = 1'b0;
        if (mid_write && k == 0 && s == 0) begin
          x_wr_en = 1'b1; x_wr_addr = 2'd2; x_wr_data = 5'd9;
          w_wr_en = 1'b1; w_wr_row = 2'd1; w_wr_col = 2'd1; w_wr_data = 5'd0;
          err_exp = 1'b1;
        end
        @(posedge clk); #1;
        x_wr_en = 1'b0; w_wr_en = 1'b0;
        cyc++;
      end
    end
    start = 1'b0; row_ready = 1'b0;
    checks++;
    if ({busy, row_valid, done, wr_err} !== {1'b0, 1'b0, 1'b1, err_exp}) begin
      errors++; $display("FAIL done_status got %b exp %b", {busy, row_valid, done, wr_err},
                         {1'b0, 1'b0, 1'b1, err_exp});
    end
    checks++;
    if (cyc != 1 + int'(N) + total_stall) begin
      errors++; $display("FAIL done_latency got %0d exp %0d", cyc, 1 + int'(N) + total_stall);
    end
    checks++;
    if (beats != int'(N)) begin
      errors++; $display("FAIL beat_count got %0d exp %0d", beats, N);
    end
    if (done_write) begin
      x_wr_en = 1'b1; x_wr_addr = 2'd2; x_wr_data = 5'd9;
    end
    @(posedge clk); #1;
    if (done_write) begin
      x_wr_en = 1'b0; mx[2] = 5'd9;
    end
    checks++;
    if ({busy, row_valid, done, wr_err} !== 4'b0000) begin
      errors++; $display("FAIL idle_status got %b exp 0000", {busy, row_valid, done, wr_err});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if ({busy, row_valid, done, wr_err, row_idx} !== '0) begin
      errors++; $display("FAIL %s_ctrl got %b exp 0", tag, {busy, row_valid, done, wr_err, row_idx});
    end
    checks++;
    if (row_w !== '0 || x_vec !== '0) begin
      errors++; $display("FAIL %s_data got row_w=%h x_vec=%h exp 0", tag, row_w, x_vec);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset_held");
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    check_reset_outputs("reset_release");
  endtask

  task automatic test_basic_pass();
    do_pass(-1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_stall();
    logic [N*W-1:0] exp_x;
    write_x(0, 5'd3); write_x(1, 5'd7); write_x(2, 5'd1); write_x(3, 5'd5);
    do_pass(1, 3, 1'b0, 1'b0, 1'b0);
    exp_x = {5'd5, 5'd1, 5'd7, 5'd3};
    checks++;
    if (x_vec !== exp_x) begin
      errors++; $display("FAIL stall_xvec got %h exp %h", x_vec, exp_x);
    end
  endtask

  task automatic test_busy_write();
    logic [W-1:0] got;
    do_pass(-1, 0, 1'b1, 1'b0, 1'b1);
    do_pass(-1, 0, 1'b0, 1'b0, 1'b0);
    got = x_vec[2*W +: W];
    checks++;
    if (got !== 5'd9) begin
      errors++; $display("FAIL done_write_x2 got %0d exp 9", got);
    end
  endtask

  task automatic test_w_write();
    write_w(2, 1, 5'b00111);
    do_pass(2, 1, 1'b0, 1'b0, 1'b0);
    do_pass(0, 2, 1'b0, 1'b1, 1'b0);
    do_pass(-1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      repeat ($urandom_range(0, 3)) write_x($urandom_range(0, N-1), W'($urandom));
      repeat ($urandom_range(0, 3))
        write_w($urandom_range(0, N-1), $urandom_range(0, N-1), W'($urandom));
      do_pass($urandom_range(0, N-1), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
    end
  endtask

  task automatic test_back_to_back();
    do_pass(-1, 0, 1'b0, 1'b0, 1'b0);
    do_pass(-1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    write_x(1, 5'd12);
    write_w(3, 0, 5'd1);
    start = 1'b1; row_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    row_ready = 1'b0;
    checks++;
    if (row_idx !== 2'd2 || busy !== 1'b1) begin
      errors++; $display("FAIL mid_pre_reset got idx=%0d busy=%b exp idx=2 busy=1", row_idx, busy);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("reset_async");
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check_reset_outputs("reset_mid_after");
    do_pass(-1, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_range3();
    logic [W-1:0] e3 [3][3];
    logic [3*W-1:0] er;
    logic [3*W-1:0] ex;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) e3[r][c] = (r == c) ? DG : OD;
    x3_en = 1'b1; x3_addr = 2'd3; x3_data = 5'h1f;
    @(posedge clk); #1; x3_en = 1'b0;
    checks++;
    if (err3 !== 1'b1) begin errors++; $display("FAIL range_x_err got %b exp 1", err3); end
    w3_en = 1'b1; w3_row = 2'd3; w3_col = 2'd0; w3_data = 5'h15;
    @(posedge clk); #1;
    w3_row = 2'd0; w3_col = 2'd3;
    checks++;
    if (err3 !== 1'b1) begin errors++; $display("FAIL range_wrow_err got %b exp 1", err3); end
    @(posedge clk); #1;
    w3_row = 2'd1; w3_col = 2'd0; w3_data = 5'b00101;
    e3[1][0] = 5'b00101;
    checks++;
    if (err3 !== 1'b1) begin errors++; $display("FAIL range_wcol_err got %b exp 1", err3); end
    @(posedge clk); #1;
    w3_en = 1'b0;
    x3_en = 1'b1; x3_addr = 2'd1; x3_data = 5'd6;
    checks++;
    if (err3 !== 1'b0) begin errors++; $display("FAIL range_ok_err got %b exp 0", err3); end
    @(posedge clk); #1;
    x3_en = 1'b0;
    start3 = 1'b1; rdy3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    ex = {5'd0, 5'd6, 5'd0};
    for (int k = 0; k < 3; k++) begin
      for (int c = 0; c < 3; c++) er[c*W +: W] = e3[k][c];
      checks++;
      if (idx3 !== 2'(k) || valid3 !== 1'b1 || row_w3 !== er || x_vec3 !== ex) begin
        errors++; $display("FAIL range_row k=%0d got idx=%0d v=%b w=%h x=%h exp w=%h x=%h",
                           k, idx3, valid3, row_w3, x_vec3, er, ex);
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({done3, valid3, busy3} !== 3'b100) begin
      errors++; $display("FAIL range_done got %b exp 100", {done3, valid3, busy3});
    end
    rdy3 = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    x_wr_en = 1'b0; w_wr_en = 1'b0; start = 1'b0; row_ready = 1'b0;
    x_wr_addr = '0; x_wr_data = '0; w_wr_row = '0; w_wr_col = '0; w_wr_data = '0;
    x3_en = 1'b0; w3_en = 1'b0; start3 = 1'b0; rdy3 = 1'b0;
    x3_addr = '0; x3_data = '0; w3_row = '0; w3_col = '0; w3_data = '0;
    model_reset();
    test_reset();
    test_basic_pass();
    test_stall();
    test_busy_write();
    test_w_write();
    test_random();
    test_back_to_back();
    test_reset_mid();
    test_range3();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
